// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - ALU opcode and operand-source types shared with the decoder
package decoder_pkg;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_AND    = 4'd2,
        ALU_OR     = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_SLL    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_SLT    = 4'd8,
        ALU_PASS_B = 4'd9
    } alu_opcode_t;

    // Selects where ALU operand B comes from
    typedef enum logic {
        S1_REG = 1'b0,
        S1_IMM = 1'b1
    } alu_s1_font_t;

endpackage

// File: rtl/reg_pkg.sv
// rtl/reg_pkg.sv - register-read forward bundle and execute/writeback entry types
package reg_pkg;
    import decoder_pkg::*;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;
    localparam int IMM_W = 12;

    typedef logic [REG_W-1:0] reg_t;

    // Bundle forwarded by the register-read stage alongside the operand values
    typedef struct packed {
        alu_s1_font_t       alu_s1_font;
        alu_opcode_t        alu_opcode;
        logic               wb_wr;
        reg_t               reg_dst;
        logic [IMM_W-1:0]   imm;
    } reg_fur_sig_t;

    localparam int EXE_STATE_NUM  = 2;
    localparam int EXE_STATE_BITS = $clog2(EXE_STATE_NUM);

    typedef enum logic [EXE_STATE_BITS-1:0] {
        exe_nope = 1'b0,
        exe_next = 1'b1
    } exe_state_t;

    // Result held between execute and the register-file write port
    typedef struct packed {
        logic               wb_wr;
        reg_t               reg_dst;
        logic [XLEN-1:0]    data;
    } exe_wb_sig_t;

endpackage

// File: rtl/alu_unit.sv
// rtl/alu_unit.sv - combinational integer ALU
module alu_unit
    import decoder_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  alu_opcode_t         opcode,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic [DATA_W-1:0]   result
);

    localparam int SHAMT_W = $clog2(DATA_W);

    logic [SHAMT_W-1:0] shamt;
    logic               lt;

    assign shamt = b[SHAMT_W-1:0];
    assign lt    = $signed(a) < $signed(b);

    // Operation select; unknown encodings yield zero
    always_comb begin
        result = '0;
        case (opcode)
            ALU_ADD:    result = a + b;
            ALU_SUB:    result = a - b;
            ALU_AND:    result = a & b;
            ALU_OR:     result = a | b;
            ALU_XOR:    result = a ^ b;
            ALU_SLL:    result = a << shamt;
            ALU_SRL:    result = a >> shamt;
            ALU_SRA:    result = $unsigned($signed(a) >>> shamt);
            ALU_SLT:    result = {{(DATA_W-1){1'b0}}, lt};
            ALU_PASS_B: result = b;
            default:    result = '0;
        endcase
    end

endmodule

// File: rtl/exe_wb_stage.sv
// rtl/exe_wb_stage.sv - execute stage with single-entry result register and writeback
module exe_wb_stage
    import decoder_pkg::*;
    import reg_pkg::*;
#(
    parameter int DATA_W     = XLEN,
    parameter int REG_ADDR_W = REG_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  reg_fur_sig_t            in_sig,
    input  logic [DATA_W-1:0]       in_s0_data,
    input  logic [DATA_W-1:0]       in_s1_data,
    input  logic                    wb_ready,
    output logic                    wb_wr_en,
    output logic [REG_ADDR_W-1:0]   wb_reg_dst,
    output logic [DATA_W-1:0]       wb_data,
    output logic                    fwd_valid,
    output logic [REG_ADDR_W-1:0]   fwd_reg_dst,
    output logic [DATA_W-1:0]       fwd_data,
    output exe_state_t              exe_state
);

    exe_state_t         state_q, state_d;
    exe_wb_sig_t        entry_q;
    logic               is_next;
    logic               retire;
    logic               accept;
    logic [DATA_W-1:0]  imm_ext;
    logic [DATA_W-1:0]  opnd_b;
    logic [DATA_W-1:0]  alu_result;

    assign is_next = (state_q == exe_next);

    // Entries that do not write retire without waiting for the write port
    assign retire   = is_next && (wb_ready || !entry_q.wb_wr);
    assign in_ready = !flush && (!is_next || retire);
    assign accept   = in_valid && in_ready;

    assign imm_ext = {{(DATA_W-IMM_W){in_sig.imm[IMM_W-1]}}, in_sig.imm};
    assign opnd_b  = (in_sig.alu_s1_font == S1_IMM) ? imm_ext : in_s1_data;

    alu_unit #(
        .DATA_W (DATA_W)
    ) u_alu (
        .opcode (in_sig.alu_opcode),
        .a      (in_s0_data),
        .b      (opnd_b),
        .result (alu_result)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= exe_nope;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: flush empties the entry, otherwise fill on accept and drain on retire
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = exe_nope;
        end else begin
            case (state_q)
                exe_nope: if (accept) state_d = exe_next;
                exe_next: if (retire) state_d = accept ? exe_next : exe_nope;
                default:  state_d = exe_nope;
            endcase
        end
    end

    // Held entry: load the new result on accept, clear when dropped or drained
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            entry_q <= '0;
        end else if (accept) begin
            entry_q.wb_wr   <= in_sig.wb_wr;
            entry_q.reg_dst <= in_sig.reg_dst;
            entry_q.data    <= alu_result;
        end else if (retire) begin
            entry_q <= '0;
        end
    end

    // Writeback and bypass views of the held entry, zero while empty
    always_comb begin
        wb_wr_en    = is_next && entry_q.wb_wr && wb_ready && !flush;
        wb_reg_dst  = '0;
        wb_data     = '0;
        fwd_valid   = is_next && entry_q.wb_wr;
        fwd_reg_dst = '0;
        fwd_data    = '0;
        if (is_next) begin
            wb_reg_dst  = entry_q.reg_dst;
            wb_data     = entry_q.data;
            fwd_reg_dst = entry_q.reg_dst;
            fwd_data    = entry_q.data;
        end
    end

    assign exe_state = state_q;

endmodule

// File: tb/tb_exe_wb_stage.sv
// tb/tb_exe_wb_stage.sv - self-checking bench for exe_wb_stage
module tb_exe_wb_stage;
    import decoder_pkg::*;
    import reg_pkg::*;

    logic           clk;
    logic           rst;
    logic           flush;
    logic           in_valid;
    logic           in_ready;
    reg_fur_sig_t   in_sig;
    logic [31:0]    in_s0_data;
    logic [31:0]    in_s1_data;
    logic           wb_ready;
    logic           wb_wr_en;
    logic [4:0]     wb_reg_dst;
    logic [31:0]    wb_data;
    logic           fwd_valid;
    logic [4:0]     fwd_reg_dst;
    logic [31:0]    fwd_data;
    exe_state_t     exe_state;

    exe_wb_stage dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sig      (in_sig),
        .in_s0_data  (in_s0_data),
        .in_s1_data  (in_s1_data),
        .wb_ready    (wb_ready),
        .wb_wr_en    (wb_wr_en),
        .wb_reg_dst  (wb_reg_dst),
        .wb_data     (wb_data),
        .fwd_valid   (fwd_valid),
        .fwd_reg_dst (fwd_reg_dst),
        .fwd_data    (fwd_data),
        .exe_state   (exe_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic        font;
        logic [31:0] s0;
        logic [31:0] s1;
        logic [11:0] imm;
        logic [4:0]  dst;
        logic [31:0] exp;
    } vec_t;

    typedef struct packed {
        logic [4:0]  dst;
        logic [31:0] data;
    } sb_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];
    sb_t  sb [$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic set_bundle(input logic [3:0] op, input logic font, input logic [31:0] s0,
                              input logic [31:0] s1, input logic [11:0] imm,
                              input logic [4:0] dst, input logic wr);
        in_sig.alu_opcode  = alu_opcode_t'(op);
        in_sig.alu_s1_font = alu_s1_font_t'(font);
        in_sig.wb_wr       = wr;
        in_sig.reg_dst     = dst;
        in_sig.imm         = imm;
        in_s0_data         = s0;
        in_s1_data         = s1;
    endtask

    // Evaluate the cycle ahead of the clock edge: retire writes against the scoreboard,
    // then record the bundle the stage is expected to take.
    task automatic settle(input logic exp_ready, input logic [31:0] exp_data);
        sb_t e;
        #1;
        if (wb_wr_en === 1'b1) begin
            if (sb.size() == 0) begin
                chk("wb_wr_en_unexpected", 32'(wb_wr_en), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("wb_reg_dst", 32'(wb_reg_dst), 32'(e.dst));
                chk("wb_data", wb_data, e.data);
            end
        end
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        if (in_valid && exp_ready && in_sig.wb_wr && !rst)
            sb.push_back('{dst: in_sig.reg_dst, data: exp_data});
    endtask

    task automatic adv();
        @(negedge clk);
    endtask

    task automatic step(input logic exp_ready, input logic [31:0] exp_data);
        settle(exp_ready, exp_data);
        adv();
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_wb_wr_en"}, 32'(wb_wr_en), 32'd0);
        chk({tag, "_wb_reg_dst"}, 32'(wb_reg_dst), 32'd0);
        chk({tag, "_wb_data"}, wb_data, 32'd0);
        chk({tag, "_fwd_valid"}, 32'(fwd_valid), 32'd0);
        chk({tag, "_fwd_reg_dst"}, 32'(fwd_reg_dst), 32'd0);
        chk({tag, "_fwd_data"}, fwd_data, 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_state"}, 32'(exe_state), 32'(exe_nope));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{ALU_ADD,    1'b1, 32'h0000_0005, 32'h0000_0000, 12'hFFD, 5'd7,  32'h0000_0002};
        vecs[1]  = '{ALU_SUB,    1'b0, 32'h0000_0003, 32'h0000_0005, 12'h000, 5'd1,  32'hFFFF_FFFE};
        vecs[2]  = '{ALU_AND,    1'b0, 32'hF0F0_1234, 32'h0FF0_FFFF, 12'h000, 5'd2,  32'h00F0_1234};
        vecs[3]  = '{ALU_OR,     1'b0, 32'hF000_0000, 32'h0000_000F, 12'h000, 5'd3,  32'hF000_000F};
        vecs[4]  = '{ALU_XOR,    1'b0, 32'hFFFF_0000, 32'h0F0F_0F0F, 12'h000, 5'd4,  32'hF0F0_0F0F};
        vecs[5]  = '{ALU_SLL,    1'b0, 32'h0000_0001, 32'h0000_001F, 12'h000, 5'd5,  32'h8000_0000};
        vecs[6]  = '{ALU_SLL,    1'b0, 32'h0000_0003, 32'h0000_0021, 12'h000, 5'd6,  32'h0000_0006};
        vecs[7]  = '{ALU_SRL,    1'b0, 32'h8000_0000, 32'h0000_0004, 12'h000, 5'd8,  32'h0800_0000};
        vecs[8]  = '{ALU_SRA,    1'b0, 32'h8000_0000, 32'h0000_0004, 12'h000, 5'd9,  32'hF800_0000};
        vecs[9]  = '{ALU_SRA,    1'b1, 32'h7000_0000, 32'h0000_0000, 12'h004, 5'd10, 32'h0700_0000};
        vecs[10] = '{ALU_SLT,    1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 12'h000, 5'd11, 32'h0000_0001};
        vecs[11] = '{ALU_SLT,    1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 12'h000, 5'd12, 32'h0000_0000};
        vecs[12] = '{ALU_PASS_B, 1'b1, 32'h1234_5678, 32'h0000_0000, 12'h800, 5'd13, 32'hFFFF_F800};
        vecs[13] = '{ALU_PASS_B, 1'b0, 32'h1234_5678, 32'hDEAD_BEEF, 12'h7FF, 5'd14, 32'hDEAD_BEEF};
        vecs[14] = '{4'hF,       1'b0, 32'h1111_1111, 32'h2222_2222, 12'h000, 5'd15, 32'h0000_0000};
        vecs[15] = '{ALU_ADD,    1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 12'h000, 5'd31, 32'h0000_0001};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; wb_ready = 1'b0;
        set_bundle(ALU_ADD, 1'b0, 32'd0, 32'd0, 12'd0, 5'd0, 1'b0);
        adv(); adv(); adv();
        rst = 1'b0;
        #1;
        chk_idle_outputs("reset");
        adv();

        // Back-to-back table with the write port always free
        wb_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            set_bundle(vecs[i].op, vecs[i].font, vecs[i].s0, vecs[i].s1, vecs[i].imm, vecs[i].dst, 1'b1);
            settle(1'b1, vecs[i].exp);
            if (i > 0) chk("b2b_state", 32'(exe_state), 32'(exe_next));
            adv();
        end
        in_valid = 1'b0;
        step(1'b1, 32'd0);
        chk("b2b_drain_state", 32'(exe_state), 32'(exe_nope));

        // Backpressure: SUB 3-5 held for four cycles
        wb_ready = 1'b0;
        in_valid = 1'b1;
        set_bundle(ALU_SUB, 1'b0, 32'd3, 32'd5, 12'd0, 5'd3, 1'b1);
        step(1'b1, 32'hFFFF_FFFE);
        set_bundle(ALU_ADD, 1'b0, 32'd1, 32'd1, 12'd0, 5'd9, 1'b1);
        for (int k = 0; k < 4; k++) begin
            settle(1'b0, 32'd0);
            chk("bp_wb_wr_en", 32'(wb_wr_en), 32'd0);
            chk("bp_wb_data", wb_data, 32'hFFFF_FFFE);
            chk("bp_fwd_data", fwd_data, 32'hFFFF_FFFE);
            chk("bp_fwd_valid", 32'(fwd_valid), 32'd1);
            chk("bp_fwd_reg_dst", 32'(fwd_reg_dst), 32'd3);
            adv();
        end
        wb_ready = 1'b1;
        settle(1'b1, 32'd2);
        chk("bp_release_wr", 32'(wb_wr_en), 32'd1);
        adv();
        in_valid = 1'b0;
        step(1'b1, 32'd0);
        chk("bp_drain_state", 32'(exe_state), 32'(exe_nope));

        // No-write entry retires without the write port
        wb_ready = 1'b0;
        in_valid = 1'b1;
        set_bundle(ALU_ADD, 1'b0, 32'd10, 32'd20, 12'd0, 5'd12, 1'b0);
        step(1'b1, 32'd30);
        in_valid = 1'b0;
        settle(1'b1, 32'd0);
        chk("nowr_state", 32'(exe_state), 32'(exe_next));
        chk("nowr_fwd_valid", 32'(fwd_valid), 32'd0);
        chk("nowr_wb_wr_en", 32'(wb_wr_en), 32'd0);
        adv();
        chk("nowr_retired", 32'(exe_state), 32'(exe_nope));

        // Flush of a held entry, with the write port offered in the flush cycle
        in_valid = 1'b1;
        set_bundle(ALU_OR, 1'b0, 32'h00FF, 32'hFF00, 12'd0, 5'd4, 1'b1);
        step(1'b1, 32'h0000_FFFF);
        flush = 1'b1;
        wb_ready = 1'b1;
        set_bundle(ALU_ADD, 1'b0, 32'd7, 32'd8, 12'd0, 5'd5, 1'b1);
        #1;
        chk("flush_wb_wr_en", 32'(wb_wr_en), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        adv();
        void'(sb.pop_back());
        flush = 1'b0;
        in_valid = 1'b0;
        settle(1'b1, 32'd0);
        chk("flush_state", 32'(exe_state), 32'(exe_nope));
        chk("flush_no_wr", 32'(wb_wr_en), 32'd0);
        adv();

        // Reset while an entry is held
        wb_ready = 1'b0;
        in_valid = 1'b1;
        set_bundle(ALU_XOR, 1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 12'd0, 5'd6, 1'b1);
        step(1'b1, 32'hFFFF_FFFF);
        rst = 1'b1;
        set_bundle(ALU_ADD, 1'b0, 32'd1, 32'd2, 12'd0, 5'd8, 1'b1);
        step(1'b0, 32'd0);
        void'(sb.pop_back());
        rst = 1'b0;
        in_valid = 1'b0;
        wb_ready = 1'b1;
        #1;
        chk_idle_outputs("rst_hold");
        adv();
        step(1'b1, 32'd0);

        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/exe_wb_stage.md
Name: exe_wb_stage

Overview:
- Consumer end of the register-read stage's forward bundle. Accepts reg_fur_sig_t plus the two operand values read from the register file, and executes the ALU operation.
- Holds the result in a single-entry output register and drives the register-file write port (writeback).
- Also provides a bypass view of the in-flight result back to the register-read stage.
- Sits between the register-read stage and the register file write port in the in-order CPU pipeline.

Parameters:
- DATA_W, 32, width of operands, immediate after extension, and result.
- REG_ADDR_W, 5, width of reg_t (register index).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard accepted-but-not-written entry
- in_valid  in  1  register-read stage presents a bundle
- in_ready  out  1  stage can accept this cycle
- in_sig  in  reg_fur_sig_t  alu_s1_font, alu_opcode, wb_wr, reg_dst, imm
- in_s0_data  in  DATA_W  source-0 register value
- in_s1_data  in  DATA_W  source-1 register value
- wb_ready  in  1  register-file write port available (arbitrated)
- wb_wr_en  out  1  write strobe
- wb_reg_dst  out  REG_ADDR_W  write index
- wb_data  out  DATA_W  write data
- fwd_valid  out  1  held entry will write a register
- fwd_reg_dst  out  REG_ADDR_W  bypass index
- fwd_data  out  DATA_W  bypass data
- exe_state  out  exe_state_t  current state, for debug and hazard logic

Behaviour:
- State machine exe_state_t has two states:
  - exe_nope: entry empty.
  - exe_next: entry holds a result awaiting writeback.
- Reset: state exe_nope. All outputs 0 except in_ready, which is 1.
- Accept: the bundle is captured when in_valid && in_ready.
- Operand selection:
  - Operand A = in_s0_data.
  - Operand B = in_s1_data when alu_s1_font selects register; imm when it selects immediate.
  - imm is sign-extended to DATA_W.
- ALU ops (alu_opcode_t):
  - ADD, SUB: modulo 2^DATA_W, no flags.
  - AND, OR, XOR.
  - SLL, SRL, SRA: shift amount = B[$clog2(DATA_W)-1:0].
  - SLT: signed compare, result 0 or 1.
  - PASS_B.
  - Undefined opcode: result 0, wb_wr still honored.
- Latency: result is registered. Writeback can occur in the cycle after accept, at the earliest.
- Retire (done) = exe_next && (wb_ready || !wb_wr).
  - wb_wr_en = exe_next && wb_wr && wb_ready (combinational from wb_ready).
  - Entries with wb_wr=0 retire without asserting wb_wr_en.
- Transitions:
  - exe_nope: accept -> exe_next.
  - exe_next: retire && !accept -> exe_nope.
  - exe_next: retire && accept -> exe_next (new entry loaded; back-to-back, full throughput).
  - exe_next: !retire -> hold. Entry and outputs are stable; in_ready=0.
- in_ready = (state==exe_nope) || retire, where retire is combinational from wb_ready.
- Bypass:
  - fwd_valid = exe_next && wb_wr.
  - fwd_reg_dst and fwd_data mirror the held entry.
  - Index 0 is not special-cased here; the register-read stage handles it.
- Flush:
  - State goes to exe_nope next cycle and the held entry is dropped.
  - wb_wr_en is forced 0 in the flush cycle.
  - in_ready=0 during flush; the incoming bundle is not accepted.
- Reset mid-operation: a held entry is discarded and never written; rst has priority over flush and accept.
- wb_reg_dst and wb_data are driven from the held entry whenever exe_next is set, and are 0 in exe_nope.

Decomposition:
- reg_pkg gains:
  - EXE_STATE_NUM, EXE_STATE_BITS, exe_state_t {exe_nope, exe_next}.
  - exe_wb_sig_t {wb_wr, reg_dst, data} as the held entry type.
- alu_opcode_t and alu_s1_font_t stay in decoder_pkg.
- Sub-module alu_unit: purely combinational, (opcode, a, b) -> result. It is instantiated once and tested standalone.
- The top level holds the FSM, the entry register, and the handshake.

Test Plan:
- ADD, imm source: s0=0x0000_0005, imm=-3, reg_dst=7, wb_wr=1, wb_ready=1 -> next cycle wb_wr_en=1, wb_reg_dst=7, wb_data=0x0000_0002; state returns to exe_nope.
- Back-to-back: three bundles on consecutive cycles with wb_ready=1 -> in_ready held 1; three writebacks on consecutive cycles, in order; state stays exe_next.
- Backpressure: entry SUB 3-5 held with wb_ready=0 for 4 cycles -> in_ready=0; wb_data=0xFFFF_FFFE and fwd_data stable. wb_ready=1 -> single write; a new bundle is accepted in the same cycle.
- No-write op: wb_wr=0 with wb_ready=0 -> retires in 1 cycle; wb_wr_en never 1; fwd_valid=0.
- Flush while exe_next and wb_ready=0 -> no write ever issued for that entry; state exe_nope next cycle; in_valid in the flush cycle is not accepted.
- Reset mid-hold: rst=1 while exe_next -> next cycle all outputs 0, in_ready=1, exe_state=exe_nope. Shift checks: SRA 0x8000_0000 by 4 gives 0xF800_0000; SLT -1<1 gives 1.
